// File: rtl/smvm_frame_tx.sv
// smvm_frame_tx: serializes one SMVM input frame onto an 8-bit valid-qualified
// byte stream. Host logic loads a dense vector buffer and an ordered list of
// non-zero (value, column, end-of-row) entries while the block is idle; a start
// pulse then emits: rows, cols, vector[0..cols-1], and one (value, column, ipv)
// triple per stored non-zero. A single tx_valid-low cycle carrying done marks
// the end of the frame.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   vec_we/addr/wdata     vector buffer write port (idle only)
//   nz_we/val/col/eor     append one non-zero entry (idle only)
//   clr                   clear nnz_cnt and err_full (idle only)
//   start, rows, cols     begin a frame; rows/cols sampled on accepted start
//   tx_valid, tx_data     output stream, no backpressure
//   busy                  high from first through last valid byte
//   done                  one-cycle pulse in the cycle after the last byte
//   err_cfg               one-cycle pulse when a start is rejected
//   err_full              sticky: a non-zero was dropped on a full buffer
//   nnz_cnt               number of stored non-zeros
module smvm_frame_tx #(
  parameter int unsigned MAX_COLS = 128,
  parameter int unsigned MAX_NNZ  = 256,
  parameter int unsigned NNZ_W    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vec_we,
  input  logic [6:0]       vec_addr,
  input  logic [7:0]       vec_wdata,
  input  logic             nz_we,
  input  logic [7:0]       nz_val,
  input  logic [7:0]       nz_col,
  input  logic             nz_eor,
  input  logic             clr,
  input  logic             start,
  input  logic [7:0]       rows,
  input  logic [7:0]       cols,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             done,
  output logic             err_cfg,
  output logic             err_full,
  output logic [NNZ_W-1:0] nnz_cnt
);

  localparam int unsigned NZ_AW = $clog2(MAX_NNZ);

  typedef enum logic [2:0] {IDLE, HDR_R, HDR_C, VEC, VAL, IDX, IPV, FIN} state_t;

  // Buffers are not reset; entry layout is {eor, col, val}.
  logic [7:0]  vec_mem [MAX_COLS];
  logic [16:0] nz_mem  [MAX_NNZ];

  state_t           state_q, state_d;
  logic [7:0]       rows_q, rows_d;
  logic [7:0]       cols_q, cols_d;
  logic [7:0]       vec_idx_q, vec_idx_d;
  logic [NNZ_W-1:0] nz_idx_q, nz_idx_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_cfg_q, err_cfg_d;
  logic             err_full_q, err_full_d;
  logic [NNZ_W-1:0] nnz_cnt_q, nnz_cnt_d;

  logic             idle;
  logic             cfg_bad;
  logic             start_ok;
  logic             nz_full;
  logic             vec_wr;
  logic             nz_wr;
  logic [NNZ_W-1:0] nz_nxt;

  assign idle     = (state_q == IDLE);
  assign cfg_bad  = (cols == 8'd0) || (32'(cols) > MAX_COLS) || (rows == 8'd0);
  assign start_ok = idle && !clr && start && !cfg_bad;
  assign nz_full  = (nnz_cnt_q == NNZ_W'(MAX_NNZ));
  assign vec_wr   = idle && !clr && !start_ok && vec_we;
  assign nz_wr    = idle && !clr && !start_ok && nz_we && !nz_full;
  assign nz_nxt   = nz_idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (vec_wr) vec_mem[vec_addr] <= vec_wdata;
    if (nz_wr)  nz_mem[nnz_cnt_q[NZ_AW-1:0]] <= {nz_eor, nz_col, nz_val};
  end

  // Output registers are loaded with the byte for the next cycle, so state_q
  // names the field currently on tx_data.
  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    vec_idx_d  = vec_idx_q;
    nz_idx_d   = nz_idx_q;
    tx_valid_d = 1'b1;
    tx_data_d  = '0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    err_cfg_d  = 1'b0;
    err_full_d = err_full_q;
    nnz_cnt_d  = nnz_cnt_q;
    case (state_q)
      IDLE: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        if (clr) begin
          nnz_cnt_d  = '0;
          err_full_d = 1'b0;
        end else if (start && cfg_bad) begin
          err_cfg_d = 1'b1;
        end else if (start) begin
          rows_d     = rows;
          cols_d     = cols;
          tx_valid_d = 1'b1;
          tx_data_d  = rows;
          busy_d     = 1'b1;
          state_d    = HDR_R;
        end
        if (!clr && !start_ok && nz_we) begin
          if (nz_full) err_full_d = 1'b1;
          else         nnz_cnt_d  = nnz_cnt_q + 1'b1;
        end
      end
      HDR_R: begin
        tx_data_d = cols_q;
        state_d   = HDR_C;
      end
      HDR_C: begin
        tx_data_d = vec_mem[0];
        vec_idx_d = 8'd1;
        state_d   = VEC;
      end
      VEC: begin
        if (vec_idx_q != cols_q) begin
          tx_data_d = vec_mem[vec_idx_q[6:0]];
          vec_idx_d = vec_idx_q + 8'd1;
        end else if (nnz_cnt_q == '0) begin
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = FIN;
        end else begin
          tx_data_d = nz_mem[0][7:0];
          nz_idx_d  = '0;
          state_d   = VAL;
        end
      end
      VAL: begin
        tx_data_d = nz_mem[nz_idx_q[NZ_AW-1:0]][15:8];
        state_d   = IDX;
      end
      IDX: begin
        tx_data_d = {7'b0, nz_mem[nz_idx_q[NZ_AW-1:0]][16]};
        state_d   = IPV;
      end
      IPV: begin
        if (nz_nxt == nnz_cnt_q) begin
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = FIN;
        end else begin
          tx_data_d = nz_mem[nz_nxt[NZ_AW-1:0]][7:0];
          nz_idx_d  = nz_nxt;
          state_d   = VAL;
        end
      end
      FIN: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rows_q     <= '0;
      cols_q     <= '0;
      vec_idx_q  <= '0;
      nz_idx_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_cfg_q  <= 1'b0;
      err_full_q <= 1'b0;
      nnz_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      vec_idx_q  <= vec_idx_d;
      nz_idx_q   <= nz_idx_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_cfg_q  <= err_cfg_d;
      err_full_q <= err_full_d;
      nnz_cnt_q  <= nnz_cnt_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_cfg  = err_cfg_q;
  assign err_full = err_full_q;
  assign nnz_cnt  = nnz_cnt_q;

endmodule

// File: tb/tb_smvm_frame_tx.sv
// Directed bench for smvm_frame_tx: loads buffers, sends frames and compares
// every stream byte and status output against hand-computed values.
module tb_smvm_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vec_we;
  logic [6:0] vec_addr;
  logic [7:0] vec_wdata;
  logic       nz_we;
  logic [7:0] nz_val;
  logic [7:0] nz_col;
  logic       nz_eor;
  logic       clr;
  logic       start;
  logic [7:0] rows;
  logic [7:0] cols;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;
  logic       err_cfg;
  logic       err_full;
  logic [8:0] nnz_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  exp_b [32];

  always #5 clk = ~clk;

  smvm_frame_tx #(.MAX_COLS(128), .MAX_NNZ(256), .NNZ_W(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
    .nz_we(nz_we), .nz_val(nz_val), .nz_col(nz_col), .nz_eor(nz_eor),
    .clr(clr), .start(start), .rows(rows), .cols(cols),
    .tx_valid(tx_valid), .tx_data(tx_data), .busy(busy), .done(done),
    .err_cfg(err_cfg), .err_full(err_full), .nnz_cnt(nnz_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_vec(input logic [6:0] a, input logic [7:0] d);
    vec_we = 1'b1; vec_addr = a; vec_wdata = d;
    tick();
    vec_we = 1'b0;
  endtask

  task automatic wr_nz(input logic [7:0] v, input logic [7:0] c, input logic e);
    nz_we = 1'b1; nz_val = v; nz_col = c; nz_eor = e;
    tick();
    nz_we = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] r, input logic [7:0] c);
    start = 1'b1; rows = r; cols = c;
    tick();
    start = 1'b0;
  endtask

  // Called one cycle after the start edge; checks n bytes then the end marker.
  // disturb pulses start/clr/nz_we during byte 4.
  task automatic expect_frame(input int n, input bit disturb, input string tag);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
      chk({tag, "_busy"},  32'(busy),     32'd1);
      chk({tag, "_byte"},  32'(tx_data),  32'(exp_b[i]));
      if (disturb && i == 4) begin
        start = 1'b1; clr = 1'b1; nz_we = 1'b1; rows = 8'd9; cols = 8'd9;
      end
      tick();
      start = 1'b0; clr = 1'b0; nz_we = 1'b0;
    end
    chk({tag, "_end_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_end_data"},  32'(tx_data),  32'd0);
    chk({tag, "_done"},      32'(done),     32'd1);
    chk({tag, "_end_busy"},  32'(busy),     32'd0);
    tick();
    chk({tag, "_done_clr"},  32'(done),     32'd0);
    chk({tag, "_idle_vld"},  32'(tx_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; vec_we = 1'b0; vec_addr = '0; vec_wdata = '0;
    nz_we = 1'b0; nz_val = '0; nz_col = '0; nz_eor = 1'b0;
    clr = 1'b0; start = 1'b0; rows = '0; cols = '0;
    #23;
    chk("rst_valid",    32'(tx_valid), 32'd0);
    chk("rst_data",     32'(tx_data),  32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err_cfg",  32'(err_cfg),  32'd0);
    chk("rst_err_full", 32'(err_full), 32'd0);
    chk("rst_nnz",      32'(nnz_cnt),  32'd0);
    rst_n = 1'b1;
    tick();

    // Frame 1: vector [1,-2,3], non-zeros (5,0,0), (-7,2,1)
    wr_vec(7'd0, 8'h01); wr_vec(7'd1, 8'hFE); wr_vec(7'd2, 8'h03);
    wr_nz(8'h05, 8'd0, 1'b0); wr_nz(8'hF9, 8'd2, 1'b1);
    chk("nnz_two", 32'(nnz_cnt), 32'd2);
    exp_b[0] = 8'h01; exp_b[1] = 8'h03; exp_b[2] = 8'h01; exp_b[3] = 8'hFE;
    exp_b[4] = 8'h03; exp_b[5] = 8'h05; exp_b[6] = 8'h00; exp_b[7] = 8'h00;
    exp_b[8] = 8'hF9; exp_b[9] = 8'h02; exp_b[10] = 8'h01;
    do_start(8'd1, 8'd3);
    expect_frame(11, 1'b0, "f1");

    // Resend with start/clr/nz_we pulsed mid-frame: identical bytes, count kept
    do_start(8'd1, 8'd3);
    expect_frame(11, 1'b1, "f1_dist");
    chk("nnz_kept", 32'(nnz_cnt), 32'd2);
    chk("full_kept", 32'(err_full), 32'd0);

    // Frame 2: no non-zeros
    clr = 1'b1; tick(); clr = 1'b0;
    chk("nnz_clr", 32'(nnz_cnt), 32'd0);
    wr_vec(7'd0, 8'h7F);
    exp_b[0] = 8'h02; exp_b[1] = 8'h01; exp_b[2] = 8'h7F;
    do_start(8'd2, 8'd1);
    expect_frame(3, 1'b0, "f2");

    // Rejected configurations
    do_start(8'd1, 8'd0);
    chk("cfg0_err",   32'(err_cfg),  32'd1);
    chk("cfg0_valid", 32'(tx_valid), 32'd0);
    chk("cfg0_busy",  32'(busy),     32'd0);
    tick();
    chk("cfg0_pulse", 32'(err_cfg),  32'd0);
    chk("cfg0_busy2", 32'(busy),     32'd0);
    do_start(8'd1, 8'd200);
    chk("cfg200_err",   32'(err_cfg),  32'd1);
    chk("cfg200_valid", 32'(tx_valid), 32'd0);
    chk("cfg200_busy",  32'(busy),     32'd0);
    tick();
    do_start(8'd1, 8'd129);
    chk("cfg129_err", 32'(err_cfg), 32'd1);
    tick();
    do_start(8'd0, 8'd3);
    chk("rows0_err",   32'(err_cfg),  32'd1);
    chk("rows0_valid", 32'(tx_valid), 32'd0);
    tick();
    chk("rows0_idle", 32'(busy), 32'd0);

    // Fill beyond capacity
    for (int i = 0; i < 257; i++) wr_nz(8'(i), 8'(i), 1'b0);
    chk("nnz_full",  32'(nnz_cnt),  32'd256);
    chk("err_full",  32'(err_full), 32'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_nnz",   32'(nnz_cnt),  32'd0);
    chk("clr_full",  32'(err_full), 32'd0);
    wr_nz(8'h11, 8'd1, 1'b1);
    chk("nnz_one",   32'(nnz_cnt),  32'd1);
    clr = 1'b1; nz_we = 1'b1; tick(); clr = 1'b0; nz_we = 1'b0;
    chk("clr_wins",  32'(nnz_cnt),  32'd0);

    // Async reset during the vector phase
    wr_vec(7'd1, 8'h22); wr_vec(7'd2, 8'h33);
    do_start(8'd1, 8'd3);
    tick(); tick(); tick();
    chk("pre_rst_valid", 32'(tx_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(tx_valid), 32'd0);
    chk("arst_busy",  32'(busy),     32'd0);
    chk("arst_done",  32'(done),     32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_done",  32'(done),     32'd0);
      chk("post_rst_valid", 32'(tx_valid), 32'd0);
    end
    exp_b[0] = 8'h02; exp_b[1] = 8'h01; exp_b[2] = 8'h7F;
    do_start(8'd2, 8'd1);
    expect_frame(3, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
